// File: rtl/apb_master_bridge_if.sv
// CPU-side request and peripheral-bus signals of the bridge, grouped so the
// bridge (master) and its environment (slave) see opposite directions.
interface apb_master_bridge_if #(
    parameter int NUM_SLAVES = 4
);
    logic                  transfer;
    logic                  write_req;
    logic [31:0]           addr_in;
    logic [31:0]           wdata_in;
    logic [31:0]           ADDR;
    logic [NUM_SLAVES-1:0] SEL;
    logic                  ENABLE;
    logic                  WRITE;
    logic [31:0]           WDATA;
    logic                  READY;
    logic [31:0]           RDATA;
    logic                  SLVERR;
    logic                  access_done;
    logic [31:0]           rdata_q;
    logic                  ERR;
    logic                  ERR_STATUS;
    logic                  ERR_CLR;

    modport master (
        input  transfer, write_req, addr_in, wdata_in, READY, RDATA, SLVERR, ERR_CLR,
        output ADDR, SEL, ENABLE, WRITE, WDATA, access_done, rdata_q, ERR, ERR_STATUS
    );

    modport slave (
        output transfer, write_req, addr_in, wdata_in, READY, RDATA, SLVERR, ERR_CLR,
        input  ADDR, SEL, ENABLE, WRITE, WDATA, access_done, rdata_q, ERR, ERR_STATUS
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Load/store to peripheral-bus bridge: SETUP/ACCESS sequencing, one-hot slave
// decode, and forced error completion on decode miss or access timeout.
module apb_master_bridge #(
    parameter int NUM_SLAVES = 4,
    parameter int DEC_LSB    = 12,
    parameter int TIMEOUT    = 16
) (
    input logic                 CLK,
    input logic                 RESET,
    apb_master_bridge_if.master bus
);
    localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int HI_LSB = DEC_LSB + IDX_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    logic [1:0]       r_state;
    logic [7:0]       r_cnt;
    logic             r_miss;

    logic [IDX_W-1:0] w_idx;
    logic             w_miss;
    logic             w_timeout;
    logic             w_done;
    logic             w_err;

    // Any address bit above the index field, or an index past the last slave, is a miss.
    assign w_idx     = bus.addr_in[DEC_LSB +: IDX_W];
    assign w_miss    = (|(bus.addr_in >> HI_LSB)) || (int'(w_idx) >= NUM_SLAVES);
    assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));

    // READY beats the timeout in the same cycle; a miss ignores READY entirely.
    assign w_done = (r_state == S_ACCESS) && bus.ENABLE && (r_miss || bus.READY || w_timeout);
    assign w_err  = r_miss || (bus.READY ? bus.SLVERR : 1'b1);

    assign bus.access_done = w_done;
    assign bus.ERR         = w_done && w_err;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_miss      <= 1'b0;
            bus.ADDR    <= '0;
            bus.SEL     <= '0;
            bus.ENABLE  <= 1'b0;
            bus.WRITE   <= 1'b0;
            bus.WDATA   <= '0;
            bus.rdata_q <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.transfer) begin
                        bus.ADDR  <= bus.addr_in;
                        bus.WRITE <= bus.write_req;
                        bus.WDATA <= bus.write_req ? bus.wdata_in : '0;
                        bus.SEL   <= w_miss ? '0 : (NUM_SLAVES'(1) << w_idx);
                        r_miss    <= w_miss;
                        r_state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    bus.ENABLE <= 1'b1;
                    r_cnt      <= '0;
                    r_state    <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (w_done) begin
                        if (!r_miss && bus.READY && !bus.WRITE)
                            bus.rdata_q <= bus.RDATA;
                        bus.SEL    <= '0;
                        bus.ENABLE <= 1'b0;
                        bus.WRITE  <= 1'b0;
                        bus.WDATA  <= '0;
                        r_miss     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            bus.ERR_STATUS <= 1'b0;
        else if (w_done && w_err)
            bus.ERR_STATUS <= 1'b1;
        else if (bus.ERR_CLR)
            bus.ERR_STATUS <= 1'b0;
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench: stimulus pushes expected completions into a queue, a monitor
// pops and compares each access_done beat plus the following rdata_q.
module tb_apb_master_bridge;
    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    apb_master_bridge_if #(.NUM_SLAVES(4)) bus();

    apb_master_bridge #(.NUM_SLAVES(4), .DEC_LSB(12), .TIMEOUT(16)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        err;
        logic [31:0] rq;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sbq[$];
    exp_t me;
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;
    int   wait_n = 0;
    int   acnt   = 0;
    logic        rq_pend = 1'b0;
    logic [31:0] rq_exp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Slave model: READY after wait_n ACCESS cycles without it.
    always @(posedge CLK) begin
        #1;
        if (bus.ENABLE === 1'b1) begin
            bus.READY = (acnt == wait_n);
            acnt++;
        end else begin
            bus.READY = 1'b0;
            acnt = 0;
        end
    end

    always @(negedge CLK) begin
        if (rq_pend) begin
            chk("rdata_q", bus.rdata_q, rq_exp);
            rq_pend = 1'b0;
        end
        if (bus.access_done === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected access_done", 32'd1, 32'd0);
            end else begin
                me = sbq.pop_front();
                chk("ERR",     32'(bus.ERR),   32'(me.err));
                chk("SEL",     32'(bus.SEL),   32'(me.sel));
                chk("ADDR",    bus.ADDR,       me.addr);
                chk("WRITE",   32'(bus.WRITE), 32'(me.wr));
                chk("WDATA",   bus.WDATA,      me.wdata);
                chk("latency", 32'(cyc - me.t0), 32'(me.lat));
                rq_pend = 1'b1;
                rq_exp  = me.rq;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input logic [31:0] rd, input logic se, input int wn,
                         input logic [3:0] s, input logic er, input logic [31:0] rq,
                         input int lat, input int t0off);
        exp_t e;
        bus.addr_in   = a;
        bus.write_req = w;
        bus.wdata_in  = wd;
        bus.RDATA     = rd;
        bus.SLVERR    = se;
        wait_n        = wn;
        bus.transfer  = 1'b1;
        e.addr  = a;
        e.wr    = w;
        e.wdata = w ? wd : 32'h0;
        e.sel   = s;
        e.err   = er;
        e.rq    = rq;
        e.lat   = lat;
        e.t0    = cyc + t0off;
        sbq.push_back(e);
    endtask

    task automatic wait_done(input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge CLK);
            if (bus.access_done === 1'b1) got = 1'b1;
        end
        if (!got) begin
            checks++;
            $display("FAIL %s: access_done never seen, required within 300 cycles", nm);
        end
    endtask

    task automatic end_xfer();
        @(posedge CLK);
        #1 bus.transfer = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RESET         = 1'b1;
        bus.transfer  = 1'b0;
        bus.write_req = 1'b0;
        bus.addr_in   = '0;
        bus.wdata_in  = '0;
        bus.RDATA     = '0;
        bus.SLVERR    = 1'b0;
        bus.ERR_CLR   = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst SEL",        32'(bus.SEL),         32'h0);
        chk("rst ENABLE",     32'(bus.ENABLE),      32'h0);
        chk("rst WRITE",      32'(bus.WRITE),       32'h0);
        chk("rst ADDR",       bus.ADDR,             32'h0);
        chk("rst WDATA",      bus.WDATA,            32'h0);
        chk("rst rdata_q",    bus.rdata_q,          32'h0);
        chk("rst ERR_STATUS", 32'(bus.ERR_STATUS),  32'h0);
        chk("rst done",       32'(bus.access_done), 32'h0);
        RESET = 1'b0;
        @(negedge CLK);

        // zero-wait read
        issue(32'h0000_2004, 1'b0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0, 0, 4'b0100, 1'b0, 32'hDEAD_BEEF, 2, 0);
        @(posedge CLK);
        #1;
        chk("setup SEL",    32'(bus.SEL),    32'h4);
        chk("setup ENABLE", 32'(bus.ENABLE), 32'h0);
        wait_done("read");
        end_xfer();

        // write with 3 wait states
        issue(32'h0000_1000, 1'b1, 32'hA5A5_0F0F, 32'h1111_1111, 1'b0, 3, 4'b0010, 1'b0, 32'hDEAD_BEEF, 5, 0);
        repeat (3) @(posedge CLK);
        #1;
        chk("wait WDATA", bus.WDATA,            32'hA5A5_0F0F);
        chk("wait WRITE", 32'(bus.WRITE),       32'h1);
        chk("wait done",  32'(bus.access_done), 32'h0);
        wait_done("write");
        end_xfer();
        chk("post WDATA", bus.WDATA,      32'h0);
        chk("post WRITE", 32'(bus.WRITE), 32'h0);

        // decode miss: READY never arrives, completion must not depend on it
        issue(32'h0001_0000, 1'b0, 32'h0, 32'h2222_2222, 1'b0, 255, 4'b0000, 1'b1, 32'hDEAD_BEEF, 2, 0);
        @(posedge CLK);
        #1 chk("miss SEL", 32'(bus.SEL), 32'h0);
        wait_done("miss");
        end_xfer();
        chk("miss ERR_STATUS", 32'(bus.ERR_STATUS), 32'h1);
        bus.ERR_CLR = 1'b1;
        @(negedge CLK);
        bus.ERR_CLR = 1'b0;
        chk("clr ERR_STATUS", 32'(bus.ERR_STATUS), 32'h0);

        // timeout after 16 ACCESS cycles
        issue(32'h0000_3008, 1'b0, 32'h0, 32'h3333_3333, 1'b0, 255, 4'b1000, 1'b1, 32'hDEAD_BEEF, 17, 0);
        wait_done("timeout");
        end_xfer();
        chk("tmo ERR_STATUS", 32'(bus.ERR_STATUS), 32'h1);
        bus.ERR_CLR = 1'b1;
        @(negedge CLK);
        bus.ERR_CLR = 1'b0;

        // READY in the timeout cycle wins
        issue(32'h0000_3008, 1'b0, 32'h0, 32'h4444_4444, 1'b0, 15, 4'b1000, 1'b0, 32'h4444_4444, 17, 0);
        wait_done("tmo-edge");
        end_xfer();
        chk("edge ERR_STATUS", 32'(bus.ERR_STATUS), 32'h0);

        // slave error while ERR_CLR held: set wins
        bus.ERR_CLR = 1'b1;
        issue(32'h0000_0000, 1'b0, 32'h0, 32'h5555_5555, 1'b1, 1, 4'b0001, 1'b1, 32'h5555_5555, 3, 0);
        wait_done("slverr");
        end_xfer();
        bus.ERR_CLR = 1'b0;
        chk("slverr ERR_STATUS", 32'(bus.ERR_STATUS), 32'h1);

        // reset in ACCESS: abort with no completion
        bus.addr_in   = 32'h0000_2000;
        bus.write_req = 1'b0;
        bus.RDATA     = 32'h7777_7777;
        bus.SLVERR    = 1'b0;
        wait_n        = 255;
        bus.transfer  = 1'b1;
        repeat (4) @(negedge CLK);
        chk("pre-rst ENABLE", 32'(bus.ENABLE), 32'h1);
        #2 RESET = 1'b1;
        #1;
        chk("abort SEL",        32'(bus.SEL),         32'h0);
        chk("abort ENABLE",     32'(bus.ENABLE),      32'h0);
        chk("abort ERR_STATUS", 32'(bus.ERR_STATUS),  32'h0);
        chk("abort done",       32'(bus.access_done), 32'h0);
        chk("abort rdata_q",    bus.rdata_q,          32'h0);
        bus.transfer = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        chk("idle ENABLE", 32'(bus.ENABLE), 32'h0);

        // back-to-back load then store, transfer held high
        issue(32'h0000_2010, 1'b0, 32'h0, 32'h6666_6666, 1'b0, 0, 4'b0100, 1'b0, 32'h6666_6666, 2, 0);
        wait_done("b2b load");
        issue(32'h0000_1020, 1'b1, 32'h1234_5678, 32'h6666_6666, 1'b0, 1, 4'b0010, 1'b0, 32'h6666_6666, 3, 1);
        wait_done("b2b store");
        end_xfer();

        repeat (2) @(negedge CLK);
        chk("scoreboard empty", 32'(sbq.size()), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
